// File: rtl/button_cond_multi.sv
// Multi-channel pushbutton conditioner: synchroniser, debounce FSM and edge/auto-repeat strobes per channel.
// Latency: btn_level and btn_pulse follow a stable input change by SYNC_STAGES+DEBOUNCE_CYCLES+1 clk edges.
// Backpressure: none; btn_pulse strobes are one-cycle fire-and-forget events and are never held or queued.
module button_cond_multi #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_RATE     = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_in,
  input  logic [1:0]          edge_mode,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_pulse,
  output logic                pulse_any
);

  // Debounce counter only ever needs to reach D-1; width kept at clog2(D+1).
  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  // Repeat counter holds the number of PRESSED cycles left until the next repeat strobe.
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [REP_W-1:0] REP_FIRST  = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_RATE);
  localparam logic [REP_W-1:0] REP_ONE    = REP_W'(1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } bstate_t;

  logic                rise_en;
  logic                fall_en;
  logic                rep_en;
  logic [CHANNELS-1:0] pulse_nxt;

  // Decode the global pulse mode; it is used live every cycle, never latched.
  always_comb begin
    rise_en = 1'b0;
    fall_en = 1'b0;
    rep_en  = 1'b0;
    case (edge_mode)
      2'b00: rise_en = 1'b1;
      2'b01: fall_en = 1'b1;
      2'b10: begin
        rise_en = 1'b1;
        fall_en = 1'b1;
      end
      default: begin
        rise_en = 1'b1;
        rep_en  = 1'b1;
      end
    endcase
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    bstate_t                state;
    logic [CNT_W-1:0]       cnt;
    logic [REP_W-1:0]       rep_cnt;
    logic                   rise_evt;
    logic                   fall_evt;
    logic                   rep_evt;
    logic                   level_q;
    logic                   pulse_q;

    // Bring the raw asynchronous button level into the clk domain.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[i]};
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Detect which event the FSM will take on the coming edge, so the strobe lands with the new state.
    always_comb begin
      rise_evt = 1'b0;
      fall_evt = 1'b0;
      rep_evt  = 1'b0;
      case (state)
        PRESS_WAIT:   rise_evt = s && (cnt == CNT_LAST);
        RELEASE_WAIT: fall_evt = !s && (cnt == CNT_LAST);
        PRESSED:      rep_evt  = s && (rep_cnt == REP_ONE);
        default:      ;
      endcase
    end

    assign pulse_nxt[i] = (rise_evt && rise_en) || (fall_evt && fall_en) || (rep_evt && rep_en);

    // Press/release debounce FSM with registered level and strobe; repeat timing runs in every mode.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state   <= RELEASED;
        cnt     <= '0;
        rep_cnt <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= pulse_nxt[i];
        case (state)
          RELEASED: begin
            if (s) begin
              state <= PRESS_WAIT;
              cnt   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!s) begin
              state <= RELEASED;
            end else if (cnt == CNT_LAST) begin
              state   <= PRESSED;
              level_q <= 1'b1;
              rep_cnt <= REP_FIRST;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          PRESSED: begin
            if (!s) begin
              state   <= RELEASE_WAIT;
              cnt     <= '0;
              rep_cnt <= '0;
            end else if (rep_cnt == REP_ONE) begin
              // Reload instead of counting through zero, so the counter never wraps into a stray strobe.
              rep_cnt <= REP_RELOAD;
            end else begin
              rep_cnt <= rep_cnt - REP_ONE;
            end
          end
          RELEASE_WAIT: begin
            if (s) begin
              // Bounce back to pressed: repeat index restarts, no rise strobe.
              state   <= PRESSED;
              rep_cnt <= REP_FIRST;
            end else if (cnt == CNT_LAST) begin
              state   <= RELEASED;
              level_q <= 1'b0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= RELEASED;
          end
        endcase
      end
    end

    assign btn_level[i] = level_q;
    assign btn_pulse[i] = pulse_q;
  end

  // Aggregate strobe registered from the same next-state bits so it coincides with btn_pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pulse_any <= 1'b0;
    end else begin
      pulse_any <= |pulse_nxt;
    end
  end

endmodule

// File: tb/tb_button_cond_multi.sv
// Bench for button_cond_multi: run-length debounce model checked every cycle plus directed timing tables.
// Latency: expects level/strobe changes 7 edges after a new input sample with the bench parameters.
// Backpressure: none; the DUT strobes are observed on the falling clock edge.
module tb_button_cond_multi;
  localparam int CH = 2;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] btn_in;
  logic [1:0]    edge_mode;
  logic [CH-1:0] btn_level;
  logic [CH-1:0] btn_pulse;
  logic          pulse_any;

  int checks = 0;
  int errors = 0;

  button_cond_multi #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .edge_mode(edge_mode),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .pulse_any(pulse_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Level flips once the synchronised input has disagreed with it for DB+1 consecutive cycles.
  // Repeat index counts consecutive pressed-and-agreeing cycles.
  bit            m_valid = 1'b0;
  bit            m_lvl [CH];
  int            m_run [CH];
  int            m_idx [CH];
  logic [CH-1:0] m_pulse;
  bit            m_any;
  logic [CH-1:0] m_hist [$];

  always @(posedge clk) begin
    logic [CH-1:0] sv;
    logic [CH-1:0] np;
    bit            was_p;
    if (!rst_n) begin
      m_valid = 1'b1;
      m_hist.delete();
      for (int j = 0; j < SS; j++) m_hist.push_back('0);
      for (int c = 0; c < CH; c++) begin
        m_lvl[c] = 1'b0;
        m_run[c] = 0;
        m_idx[c] = 0;
      end
      m_pulse = '0;
      m_any   = 1'b0;
    end else if (m_valid) begin
      sv = m_hist.pop_front();
      m_hist.push_back(btn_in);
      np = '0;
      for (int c = 0; c < CH; c++) begin
        was_p = m_lvl[c] && (m_run[c] == 0);
        if (sv[c] != m_lvl[c]) m_run[c]++;
        else m_run[c] = 0;
        if (m_run[c] == DB + 1) begin
          m_lvl[c] = sv[c];
          m_run[c] = 0;
          m_idx[c] = 0;
          if (m_lvl[c]) np[c] = (edge_mode != 2'b01);
          else np[c] = (edge_mode == 2'b01) || (edge_mode == 2'b10);
        end else if (m_lvl[c] && m_run[c] == 0) begin
          if (was_p) begin
            m_idx[c]++;
            if (edge_mode == 2'b11 && m_idx[c] >= RD && ((m_idx[c] - RD) % RR) == 0) np[c] = 1'b1;
          end else begin
            m_idx[c] = 0;
          end
        end
      end
      m_pulse = np;
      m_any   = |np;
    end
  end

  // Compare DUT against the model on every falling edge once the model has seen a reset.
  always @(negedge clk) begin
    logic [CH-1:0] ml;
    if (m_valid) begin
      for (int c = 0; c < CH; c++) ml[c] = m_lvl[c];
      chk("model_level", int'(btn_level), int'(ml));
      chk("model_pulse", int'(btn_pulse), int'(m_pulse));
      chk("model_any", int'(pulse_any), int'(m_any));
    end
  end

  // ---------------- directed observation ----------------
  int o_pc0, o_pc1, o_any, o_both, o_l0, o_l1, o_p0;

  // Observe n falling edges: pulse counts and first edge index of level change / pulse.
  task automatic obs(input int n);
    logic [CH-1:0] ls;
    ls = btn_level;
    o_pc0 = 0; o_pc1 = 0; o_any = 0; o_both = 0; o_l0 = -1; o_l1 = -1; o_p0 = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      o_pc0 += int'(btn_pulse[0]);
      o_pc1 += int'(btn_pulse[1]);
      o_any += int'(pulse_any);
      if (btn_pulse == 2'b11) o_both++;
      if (o_l0 < 0 && btn_level[0] != ls[0]) o_l0 = k;
      if (o_l1 < 0 && btn_level[1] != ls[1]) o_l1 = k;
      if (o_p0 < 0 && btn_pulse[0]) o_p0 = k;
    end
  endtask

  int rise_exp [3] = '{1, 0, 1};
  int fall_exp [3] = '{0, 1, 1};

  initial begin
    int bp, bl, r, f, got, k0;
    rst_n = 1'b0;
    btn_in = '0;
    edge_mode = 2'b00;

    // 1: reset then clean press
    repeat (3) @(negedge clk);
    chk("t1_rst_level", int'(btn_level), 0);
    chk("t1_rst_pulse", int'(btn_pulse), 0);
    chk("t1_rst_any", int'(pulse_any), 0);
    rst_n = 1'b1;
    btn_in[0] = 1'b1;
    obs(12);
    chk("t1_level_latency", o_l0, 7);
    chk("t1_pulse_edge", o_p0, 7);
    chk("t1_pulse_count", o_pc0, 1);
    chk("t1_any_count", o_any, 1);

    // 2: bounce rejection then a real press
    btn_in[0] = 1'b0;
    obs(12);
    bp = 0; bl = 0;
    btn_in[0] = 1'b1; obs(3);  bp += o_pc0; bl += (o_l0 >= 0);
    btn_in[0] = 1'b0; obs(2);  bp += o_pc0; bl += (o_l0 >= 0);
    btn_in[0] = 1'b1; obs(4);  bp += o_pc0; bl += (o_l0 >= 0);
    btn_in[0] = 1'b0; obs(12); bp += o_pc0; bl += (o_l0 >= 0);
    chk("t2_bounce_pulses", bp, 0);
    chk("t2_bounce_level", bl, 0);
    btn_in[0] = 1'b1;
    obs(12);
    chk("t2_press_pulses", o_pc0, 1);
    btn_in[0] = 1'b0;
    obs(12);

    // 3: rise/fall gating by mode
    for (int m = 0; m < 3; m++) begin
      edge_mode = 2'(m);
      btn_in[0] = 1'b1;
      obs(12);
      r = o_pc0;
      btn_in[0] = 1'b0;
      obs(12);
      f = o_pc0;
      chk($sformatf("t3_rise_mode%0d", m), r, rise_exp[m]);
      chk($sformatf("t3_fall_mode%0d", m), f, fall_exp[m]);
      chk($sformatf("t3_release_latency_mode%0d", m), o_l0, 7);
    end

    // 4: auto-repeat over 30 pressed cycles
    edge_mode = 2'b11;
    btn_in[0] = 1'b1;
    obs(7);
    chk("t4_rise_edge", o_p0, 7);
    got = (o_p0 == 7) ? 1 : 0;
    for (int idx = 1; idx <= 29; idx++) begin
      @(negedge clk);
      if (btn_pulse[0]) got |= (1 << idx);
      if (idx == 27) btn_in[0] = 1'b0;
    end
    chk("t4_repeat_mask", got, 32'h1249_2401);
    obs(15);
    chk("t4_after_release_pulses", o_pc0, 0);

    // 5: simultaneous channels, then staggered release
    edge_mode = 2'b10;
    btn_in = 2'b11;
    obs(12);
    chk("t5_both_cycles", o_both, 1);
    chk("t5_any_cycles", o_any, 1);
    chk("t5_ch1_latency", o_l1, 7);
    btn_in[0] = 1'b0;
    obs(2);
    btn_in[1] = 1'b0;
    obs(14);
    chk("t5_ch0_fall_edge", o_l0, 5);
    chk("t5_ch1_fall_edge", o_l1, 7);
    chk("t5_any_release", o_any, 2);

    // 6a: reset in PRESS_WAIT with cnt=2
    edge_mode = 2'b00;
    btn_in[0] = 1'b1;
    obs(5);
    chk("t6a_pre_reset_pulses", o_pc0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6a_rst_outputs", int'({btn_level, btn_pulse, pulse_any}), 0);
    rst_n = 1'b1;
    obs(12);
    chk("t6a_rise_edge", o_p0, 7);
    chk("t6a_pulse_count", o_pc0, 1);

    // 6b: reset at repeat index 8
    btn_in[0] = 1'b0;
    obs(12);
    edge_mode = 2'b11;
    btn_in[0] = 1'b1;
    obs(7);
    k0 = o_p0;
    chk("t6b_rise_edge", k0, 7);
    obs(8);
    chk("t6b_idx1_8_pulses", o_pc0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6b_rst_outputs", int'({btn_level, btn_pulse, pulse_any}), 0);
    rst_n = 1'b1;
    obs(12);
    chk("t6b_rise_edge_after_rst", o_p0, 7);
    chk("t6b_pulse_count", o_pc0, 1);

    btn_in = '0;
    obs(12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/button_cond_multi.md
Name: button_cond_multi

Overview:
Parametrised multi-channel button conditioner. It is the successor to the single-channel rising-edge pulse FSM. Each channel has:
- an N-stage input synchroniser,
- a debounce counter,
- a 4-state press/release FSM,
- a configurable pulse generator: rise, fall, both, or rise with auto-repeat.

It sits between raw board pushbuttons and control logic that consumes one-cycle command strobes.

Parameters:
CHANNELS, 4, number of independent button channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_CYCLES, 1000, debounce count D (>=1); counter width clog2(D+1)
REPEAT_DELAY, 500000, cycles from press pulse to first repeat pulse (>=1)
REPEAT_RATE, 100000, cycles between subsequent repeat pulses (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
btn_in  input  CHANNELS  raw asynchronous button levels, bit i = channel i
edge_mode  input  2  pulse mode, global to all channels: 00 rise, 01 fall, 10 both, 11 rise+auto-repeat
btn_level  output  CHANNELS  debounced, registered level per channel
btn_pulse  output  CHANNELS  registered one-cycle event strobe per channel
pulse_any  output  1  registered OR of the btn_pulse next-state bits; high in the same cycle as any btn_pulse bit

Behaviour:

Reset:
- rst_n sampled low at a clk edge clears all synchroniser flops, debounce counters and repeat counters.
- All FSMs go to RELEASED.
- btn_level, btn_pulse and pulse_any are 0 after that edge.
- Reset mid-debounce or mid-repeat aborts the operation and emits no pulse.

Synchroniser:
- Per-channel chain of SYNC_STAGES flops; the last stage is s_i.

Per-channel FSM (all channels identical and independent):
- RELEASED: s_i=1 -> PRESS_WAIT with cnt=0; else stay.
- PRESS_WAIT: s_i=0 -> RELEASED (bounce rejected, no pulse). s_i=1 and cnt==D-1 -> PRESSED. Otherwise cnt++.
- PRESSED: s_i=0 -> RELEASE_WAIT with cnt=0; else stay.
- RELEASE_WAIT: s_i=1 -> PRESSED (bounce rejected, no pulse). s_i=0 and cnt==D-1 -> RELEASED. Otherwise cnt++.
- Debounce requires s_i stable for D+1 consecutive cycles.
- Latency: btn_level changes SYNC_STAGES+D+1 edges after the first edge that samples the new btn_in value.

Outputs:
- btn_level_i = 1 in PRESSED and RELEASE_WAIT; 0 in RELEASED and PRESS_WAIT. Registered with the state.
- Rise event = first cycle in PRESSED entered from PRESS_WAIT. Re-entry from RELEASE_WAIT is not a rise event.
- Fall event = first cycle in RELEASED entered from RELEASE_WAIT.
- btn_pulse_i is high exactly for the event cycle, as gated by edge_mode:
  - 00: rise only
  - 01: fall only
  - 10: rise and fall
  - 11: rise plus repeat

Auto-repeat:
- Index PRESSED cycles from 0 at the rise-event cycle.
- Repeat pulses occur at indices REPEAT_DELAY, REPEAT_DELAY+REPEAT_RATE, REPEAT_DELAY+2*REPEAT_RATE, and so on.
- The repeat counter runs in every mode; only the pulse output is gated by mode.
- Any exit from PRESSED (to RELEASE_WAIT) clears repeat timing.
- A bounce back from RELEASE_WAIT restarts the index at 0 with no rise pulse.
- The repeat counter saturates/reloads and never wraps into a spurious pulse.

Other rules:
- edge_mode is sampled every cycle with no latching. A change affects only pulses from the next cycle onward; state and counters are unaffected.
- Simultaneous events on several channels produce simultaneous pulse bits; none are dropped or serialised.
- A button held through reset is debounced after reset release and produces a rise event.

Test Plan:
Bench values: CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
1. Reset and clean press: hold rst_n=0 for 3 cycles, then release; btn_in[0] 0->1 held, mode 00 -> all outputs 0 during and after reset; btn_level[0] and btn_pulse[0] rise on edge 7 after first sampling; pulse lasts 1 cycle; pulse_any matches.
2. Bounce rejection: btn_in[0] high for 3 cycles, low 2, high 4, low -> btn_level[0] and btn_pulse[0] stay 0. Then btn_in[0] high for 5+ cycles -> a single pulse.
3. Release and modes: press then release channel 0 under modes 00, 01 and 10 -> pulse counts (rise, fall) are (1,0), (0,1), (1,1). btn_level falls 7 edges after the release sample.
4. Auto-repeat: mode 11, hold channel 0 for 30 PRESSED cycles -> pulses at PRESSED indices 0, 10, 13, 16, 19, 22, 25, 28. Release -> no further pulses and no fall pulse.
5. Multi-channel simultaneity: both channels pressed in the same cycle, mode 10 -> btn_pulse=2'b11 in one cycle and pulse_any=1 for one cycle. Channel 1 releasing mid-debounce of channel 0 gives independent timing.
6. Reset mid-operation: assert rst_n=0 at PRESS_WAIT cnt=2, and separately at REPEAT index 8 -> no pulse; outputs 0 on the next edge. Button still held after reset release -> rise pulse 7 edges later.
